// File: rtl/btn_inst_capture_pkg.sv
// Shared definitions for the nexys3 instruction path: FSM state encodings,
// opcode constants and instruction-word field positions used by the decoder.
package btn_inst_capture_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ARM  = 2'b01,
    S_FIRE = 2'b10,
    S_HOLD = 2'b11
  } state_t;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b10;
  localparam logic [1:0] OP_SEND = 2'b11;

  // Instruction word layout: {op[7:6], ra[5:4], rb/immd[3:0]}
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 6;
  localparam int RA_MSB = 5;
  localparam int RA_LSB = 4;
  localparam int RB_MSB = 3;
  localparam int RB_LSB = 0;

  function automatic logic [1:0] inst_op(input logic [7:0] wd);
    return wd[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/btn_inst_capture_sync_ff.sv
// Multi-stage flop chain bringing asynchronous inputs into the clk domain.
module sync_ff #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] chain [STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/btn_inst_capture.sv
// Debounced execute-button front end: captures the switch word once per clean
// press, emits a one-cycle inst_vld pulse and counts issued instructions.
module btn_inst_capture
  import btn_inst_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 100000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic [7:0] sw,
  output logic       inst_vld,
  output logic [7:0] inst_wd,
  output logic [7:0] inst_cnt
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic             btn_s;
  logic [7:0]       sw_s;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] db_cnt_next;

  sync_ff #(.W(1), .STAGES(SYNC_STAGES)) u_sync_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn),
    .q     (btn_s)
  );

  sync_ff #(.W(8), .STAGES(SYNC_STAGES)) u_sync_sw (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sw),
    .q     (sw_s)
  );

  // Any glitch during press or release debounce restarts the stability count.
  always_comb begin
    state_next  = state;
    db_cnt_next = db_cnt;
    case (state)
      S_IDLE: begin
        db_cnt_next = '0;
        if (btn_s) state_next = S_ARM;
      end
      S_ARM: begin
        if (btn_s) begin
          if (db_cnt == DB_LAST) begin
            state_next  = S_FIRE;
            db_cnt_next = '0;
          end else begin
            db_cnt_next = db_cnt + CNT_W'(1);
          end
        end else begin
          state_next  = S_IDLE;
          db_cnt_next = '0;
        end
      end
      S_FIRE: begin
        state_next  = S_HOLD;
        db_cnt_next = '0;
      end
      S_HOLD: begin
        if (!btn_s) begin
          if (db_cnt == DB_LAST) begin
            state_next  = S_IDLE;
            db_cnt_next = '0;
          end else begin
            db_cnt_next = db_cnt + CNT_W'(1);
          end
        end else begin
          db_cnt_next = '0;
        end
      end
      default: begin
        state_next  = S_IDLE;
        db_cnt_next = '0;
      end
    endcase
  end

  // Capture happens on the edge that leaves S_FIRE, so the pulse and the new word appear together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      db_cnt   <= '0;
      inst_vld <= 1'b0;
      inst_wd  <= 8'h00;
      inst_cnt <= 8'h00;
    end else begin
      state    <= state_next;
      db_cnt   <= db_cnt_next;
      inst_vld <= (state == S_FIRE);
      if (state == S_FIRE) begin
        inst_wd  <= sw_s;
        inst_cnt <= inst_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_btn_inst_capture.sv
// Directed bench for btn_inst_capture with a short debounce window (DB_CYCLES=16).
module tb_btn_inst_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       inst_vld;
  logic [7:0] inst_wd;
  logic [7:0] inst_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int pulse_cyc = 0;
  int cyc0 = 0;
  int base = 0;

  // Edge E0 + SYNC_STAGES + DB_CYCLES + 1 is seen at the 20th falling edge after driving btn.
  localparam int LAT = 20;

  btn_inst_capture #(
    .SYNC_STAGES (2),
    .DB_CYCLES   (16),
    .CNT_W       (17)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .sw       (sw),
    .inst_vld (inst_vld),
    .inst_wd  (inst_wd),
    .inst_cnt (inst_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (inst_vld === 1'b1) begin
        pulses++;
        pulse_cyc = cyc;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    // Button and switches active throughout reset must not fire
    rst_n = 1'b0; btn = 1'b1; sw = 8'hFF;
    step(5);
    check("rst_vld", 32'(inst_vld), 32'd0);
    check("rst_wd", 32'(inst_wd), 32'h00);
    check("rst_cnt", 32'(inst_cnt), 32'h00);
    rst_n = 1'b1; btn = 1'b0;
    step(40);
    check("post_rst_pulses", 32'(pulses), 32'd0);
    check("post_rst_cnt", 32'(inst_cnt), 32'h00);
    check("post_rst_wd", 32'(inst_wd), 32'h00);

    // Clean long press
    base = pulses; sw = 8'h04; btn = 1'b1; cyc0 = cyc;
    step(100);
    check("p1_pulses", 32'(pulses - base), 32'd1);
    check("p1_latency", 32'(pulse_cyc - cyc0), 32'(LAT));
    check("p1_wd", 32'(inst_wd), 32'h04);
    check("p1_cnt", 32'(inst_cnt), 32'h01);
    check("p1_vld_low", 32'(inst_vld), 32'd0);
    btn = 1'b0;
    step(30);
    check("p1_release", 32'(pulses - base), 32'd1);

    // Bouncy press
    base = pulses; sw = 8'h93;
    btn = 1'b1; step(5);
    btn = 1'b0; step(2);
    btn = 1'b1; step(5);
    btn = 1'b0; step(1);
    check("p2_bounce", 32'(pulses - base), 32'd0);
    btn = 1'b1; cyc0 = cyc;
    step(60);
    check("p2_pulses", 32'(pulses - base), 32'd1);
    check("p2_latency", 32'(pulse_cyc - cyc0), 32'(LAT));
    check("p2_wd", 32'(inst_wd), 32'h93);
    check("p2_cnt", 32'(inst_cnt), 32'h02);

    // Long hold with switch change mid-hold
    btn = 1'b0; step(30);
    base = pulses; sw = 8'h4B; btn = 1'b1; cyc0 = cyc;
    step(250);
    sw = 8'hC0;
    step(250);
    check("p3_pulses", 32'(pulses - base), 32'd1);
    check("p3_latency", 32'(pulse_cyc - cyc0), 32'(LAT));
    check("p3_wd", 32'(inst_wd), 32'h4B);
    check("p3_cnt", 32'(inst_cnt), 32'h03);

    // Release bounce, then a too-short low gap, then a real release and press
    base = pulses;
    btn = 1'b0; step(3);
    btn = 1'b1; step(2);
    btn = 1'b0; step(10);
    btn = 1'b1; step(40);
    check("p4_short_gap", 32'(pulses - base), 32'd0);
    btn = 1'b0; step(30);
    check("p4_release", 32'(pulses - base), 32'd0);
    btn = 1'b1; cyc0 = cyc;
    step(40);
    check("p4_pulses", 32'(pulses - base), 32'd1);
    check("p4_latency", 32'(pulse_cyc - cyc0), 32'(LAT));
    check("p4_wd", 32'(inst_wd), 32'hC0);
    check("p4_cnt", 32'(inst_cnt), 32'h04);

    // Reset mid-arm discards the pending press; held button restarts full debounce
    btn = 1'b0; step(30);
    base = pulses; sw = 8'h5A; btn = 1'b1;
    step(10);
    rst_n = 1'b0;
    step(1);
    check("p5_rst_vld", 32'(inst_vld), 32'd0);
    check("p5_rst_cnt", 32'(inst_cnt), 32'h00);
    check("p5_rst_wd", 32'(inst_wd), 32'h00);
    rst_n = 1'b1; cyc0 = cyc;
    step(19);
    check("p5_no_early", 32'(pulses - base), 32'd0);
    step(30);
    check("p5_pulses", 32'(pulses - base), 32'd1);
    check("p5_latency", 32'(pulse_cyc - cyc0), 32'(LAT));
    check("p5_wd", 32'(inst_wd), 32'h5A);
    check("p5_cnt", 32'(inst_cnt), 32'h01);

    // Counter wrap
    btn = 1'b0; step(30);
    force dut.inst_cnt = 8'hFF;
    step(1);
    release dut.inst_cnt;
    base = pulses; sw = 8'h81; btn = 1'b1; cyc0 = cyc;
    step(40);
    check("wrap_pulses", 32'(pulses - base), 32'd1);
    check("wrap_cnt", 32'(inst_cnt), 32'h00);
    check("wrap_wd", 32'(inst_wd), 32'h81);
    btn = 1'b0; step(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
